// File: rtl/ram_pkg.sv
// Shared definitions for the RAM parity stage: read-sequencer state encoding
// and the default read settle time.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } rd_state_t;

    localparam int RD_WAIT_DEFAULT = 2;
    localparam int CNT_W           = 4;   // holds settle times up to 15 clocks

endpackage

// File: rtl/ls280.sv
// 9-bit odd/even parity generator/checker (74LS280 equivalent).
module ls280 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    input  logic g,
    input  logic h,
    input  logic i,
    output logic odd,
    output logic even
);

    assign odd  = ^{a, b, c, d, e, f, g, h, i};
    assign even = ~odd;

endmodule

// File: rtl/ram_parity_ctl.sv
// RAM parity stage: odd-parity bit generation on writes, delayed parity check
// on reads with sticky error/address capture, I/O channel check and NMI.
//
// state | meaning
// IDLE  | no read in progress, watching for a mem_rd rising edge
// WAIT  | read started, counting settle clocks up to RD_WAIT
// CHECK | sample data + stored parity, latch the first error
// HOLD  | sample done, waiting for mem_rd to drop
module ram_parity_ctl
    import ram_pkg::*;
#(
    parameter int RD_WAIT = RD_WAIT_DEFAULT,
    parameter int AW      = 20
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    data_in,
    input  logic          par_in,
    input  logic          par_chk_dis,
    input  logic          nmi_en,
    input  logic          io_chk_n,
    output logic          par_out,
    output logic          par_we,
    output logic          par_err,
    output logic          io_err,
    output logic [AW-1:0] err_addr,
    output logic          nmi
);

    localparam logic [CNT_W-1:0] RD_WAIT_C = CNT_W'(RD_WAIT);

    rd_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             rd_prev;
    logic             par_odd;
    logic             par_even;
    logic             par_bad;
    logic             io_sync1;
    logic             io_sync2;

    ls280 u_ls280 (
        .a    (data_in[0]),
        .b    (data_in[1]),
        .c    (data_in[2]),
        .d    (data_in[3]),
        .e    (data_in[4]),
        .f    (data_in[5]),
        .g    (data_in[6]),
        .h    (data_in[7]),
        .i    (par_in),
        .odd  (par_odd),
        .even (par_even)
    );

    // A stored word is good when its nine bits hold an odd number of ones.
    assign par_bad = par_even & ~par_odd;

    assign par_out = ~^data_in;
    assign par_we  = mem_wr & ~mem_rd;

    // rd_prev resets high so a strobe still asserted across reset release
    // is not mistaken for a fresh read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rd_prev  <= 1'b1;
            par_err  <= 1'b0;
            err_addr <= '0;
        end else begin
            rd_prev <= mem_rd;
            if (par_chk_dis) begin
                par_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (mem_rd && !rd_prev) begin
                        state <= WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!mem_rd) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == RD_WAIT_C) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (par_bad && !par_chk_dis && !par_err) begin
                        par_err  <= 1'b1;
                        err_addr <= addr;
                    end
                    cnt   <= '0;
                    state <= mem_rd ? HOLD : IDLE;
                end
                HOLD: begin
                    if (!mem_rd) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            io_sync1 <= 1'b1;
            io_sync2 <= 1'b1;
            io_err   <= 1'b0;
            nmi      <= 1'b0;
        end else begin
            io_sync1 <= io_chk_n;
            io_sync2 <= io_sync1;
            if (!io_sync2) begin
                io_err <= 1'b1;
            end
            nmi <= nmi_en & (par_err | io_err);
        end
    end

endmodule

// File: tb/tb_ram_parity_ctl.sv
// Self-checking bench for ram_parity_ctl: write-path vector table, directed
// read/abort/reset/io sequences and randomized reads against a parity model.
module tb_ram_parity_ctl;

    localparam int AW  = 20;
    localparam int RDW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mem_rd, mem_wr, par_in, par_chk_dis, nmi_en, io_chk_n;
    logic [AW-1:0] addr;
    logic [7:0]    data_in;
    logic          par_out, par_we, par_err, io_err, nmi;
    logic [AW-1:0] err_addr;

    int checks = 0;
    int errors = 0;

    ram_parity_ctl #(.RD_WAIT(RDW), .AW(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .addr        (addr),
        .data_in     (data_in),
        .par_in      (par_in),
        .par_chk_dis (par_chk_dis),
        .nmi_en      (nmi_en),
        .io_chk_n    (io_chk_n),
        .par_out     (par_out),
        .par_we      (par_we),
        .par_err     (par_err),
        .io_err      (io_err),
        .err_addr    (err_addr),
        .nmi         (nmi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       wr;
        logic       rd;
        logic       exp_out;
        logic       exp_we;
    } wvec_t;

    wvec_t wv[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ones(input logic [7:0] d);
        int n = 0;
        for (int k = 0; k < 8; k++) n += int'(d[k]);
        return n;
    endfunction

    // Ninth bit that makes the stored word odd parity.
    function automatic logic odd_fill(input logic [7:0] d);
        return (ones(d) % 2) == 0;
    endfunction

    function automatic logic word_bad(input logic [7:0] d, input logic p);
        return ((ones(d) + int'(p)) % 2) == 0;
    endfunction

    task automatic rd(input logic [AW-1:0] a, input logic [7:0] d, input logic p,
                      input int len, input int gap);
        addr    = a;
        data_in = d;
        par_in  = p;
        mem_rd  = 1'b1;
        repeat (len) tick();
        mem_rd = 1'b0;
        repeat (gap) tick();
    endtask

    logic          m_perr;
    logic [AW-1:0] m_eaddr;

    initial begin
        wv[0] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1};
        wv[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1};
        wv[2] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
        wv[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        wv[4] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
        wv[5] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1};
        wv[6] = '{8'hFE, 1'b1, 1'b1, 1'b0, 1'b0};

        reset_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; par_in = 1'b0;
        par_chk_dis = 1'b0; nmi_en = 1'b0; io_chk_n = 1'b1;
        addr = '0; data_in = '0;
        #12;
        chk("reset par_err", par_err, 0);
        chk("reset io_err", io_err, 0);
        chk("reset err_addr", err_addr, 0);
        chk("reset nmi", nmi, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Write path table; checking disabled so read rows cannot raise errors.
        par_chk_dis = 1'b1;
        foreach (wv[n]) begin
            data_in = wv[n].data;
            mem_wr  = wv[n].wr;
            mem_rd  = wv[n].rd;
            par_in  = odd_fill(wv[n].data);
            #1;
            chk($sformatf("wr par_out[%0d]", n), par_out, wv[n].exp_out);
            chk($sformatf("wr par_we[%0d]", n), par_we, wv[n].exp_we);
            tick();
            mem_rd = 1'b0;
            mem_wr = 1'b0;
            repeat (4) tick();
        end
        par_chk_dis = 1'b0;
        tick();

        // Good read
        rd(20'h12345, 8'h03, 1'b1, 5, 3);
        chk("good read par_err", par_err, 0);

        // Bad read: error lands RD_WAIT+1 edges after the strobe is seen
        nmi_en  = 1'b1;
        addr    = 20'h0ABCD; data_in = 8'h03; par_in = 1'b0; mem_rd = 1'b1;
        repeat (RDW + 1) tick();
        chk("bad read early par_err", par_err, 0);
        tick();
        chk("bad read par_err", par_err, 1);
        chk("bad read err_addr", err_addr, 20'h0ABCD);
        chk("bad read nmi lag", nmi, 0);
        tick();
        chk("bad read nmi", nmi, 1);
        mem_rd = 1'b0;
        repeat (2) tick();
        rd(20'h00001, 8'h03, 1'b0, 4, 3);
        chk("second error keeps err_addr", err_addr, 20'h0ABCD);
        chk("second error par_err", par_err, 1);

        // Clear, disabled check, masked NMI
        par_chk_dis = 1'b1;
        tick();
        chk("clear par_err", par_err, 0);
        chk("clear keeps err_addr", err_addr, 20'h0ABCD);
        rd(20'h0ABCD, 8'h03, 1'b0, 4, 3);
        chk("disabled bad read", par_err, 0);
        par_chk_dis = 1'b0;
        nmi_en = 1'b0;
        tick();
        rd(20'h55555, 8'h03, 1'b0, 4, 3);
        chk("masked par_err", par_err, 1);
        chk("masked err_addr", err_addr, 20'h55555);
        chk("masked nmi", nmi, 0);
        par_chk_dis = 1'b1;
        repeat (2) tick();
        par_chk_dis = 1'b0;
        tick();
        m_perr  = 1'b0;
        m_eaddr = 20'h55555;

        // Randomized reads against the parity model
        for (int t = 0; t < 60; t++) begin
            logic [AW-1:0] a;
            logic [7:0]    d;
            logic          p, dis, en;
            int            len;
            a   = AW'($urandom);
            d   = 8'($urandom);
            p   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 6);
            dis = ($urandom_range(0, 7) == 0);
            en  = 1'($urandom_range(0, 1));
            par_chk_dis = dis;
            nmi_en      = en;
            mem_wr      = 1'($urandom_range(0, 1));
            addr = a; data_in = d; par_in = p; mem_rd = 1'b1;
            #1;
            chk("rand par_out", par_out, odd_fill(d));
            chk("rand par_we", par_we, 0);
            repeat (len) tick();
            mem_rd = 1'b0;
            mem_wr = 1'b0;
            repeat (3) tick();
            if (dis) begin
                m_perr = 1'b0;
            end else if (len >= RDW + 1 && word_bad(d, p) && !m_perr) begin
                m_perr  = 1'b1;
                m_eaddr = a;
            end
            chk("rand par_err", par_err, m_perr);
            chk("rand err_addr", err_addr, m_eaddr);
            chk("rand nmi", nmi, en & m_perr);
        end
        par_chk_dis = 1'b1;
        repeat (2) tick();
        par_chk_dis = 1'b0;
        nmi_en = 1'b1;
        tick();

        // Aborted reads
        rd(20'h02222, 8'h03, 1'b0, 1, 4);
        chk("abort 1-cycle par_err", par_err, 0);
        rd(20'h02222, 8'h03, 1'b0, RDW, 4);
        chk("abort RD_WAIT-cycle par_err", par_err, 0);

        // I/O channel check
        io_chk_n = 1'b0;
        tick();
        io_chk_n = 1'b1;
        tick();
        chk("io_err sync delay", io_err, 0);
        tick();
        chk("io_err set", io_err, 1);
        chk("io nmi lag", nmi, 0);
        tick();
        chk("io nmi", nmi, 1);
        repeat (3) tick();
        chk("io_err sticky", io_err, 1);

        // Reset during WAIT, with a latched error present
        rd(20'h00777, 8'h03, 1'b0, 4, 3);
        chk("pre-reset par_err", par_err, 1);
        addr = 20'h00999; data_in = 8'h03; par_in = 1'b0; mem_rd = 1'b1;
        repeat (2) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid reset par_err", par_err, 0);
        chk("mid reset io_err", io_err, 0);
        chk("mid reset err_addr", err_addr, 0);
        chk("mid reset nmi", nmi, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) tick();
        chk("held strobe after reset", par_err, 0);
        mem_rd = 1'b0;
        repeat (2) tick();
        rd(20'h00ABC, 8'h03, 1'b0, 4, 3);
        chk("new read after reset", par_err, 1);
        chk("new read after reset addr", err_addr, 20'h00ABC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_parity_ctl.md
Name: ram_parity_ctl

Overview:
Parity stage wrapped around the ls280 generator/checker in the RAM subsystem. On writes it supplies the ninth (parity) bit to the parity RAM so that every stored 9-bit word has odd parity. On reads it samples the data and the stored parity bit after a programmable settle time, and latches a sticky parity error together with the failing address. It also drives the NMI request to the CPU, gated by the NMI mask, matching PC motherboard behaviour (PB4 enable/clear, PC7 status, A0 mask).

Parameters:
RD_WAIT, 2, clock cycles from the mem_rd rising edge to the data/parity sample point (1..15)
AW, 20, address width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
mem_rd  in  1  memory read strobe, active high, held for the whole cycle
mem_wr  in  1  memory write strobe, active high
addr  in  AW  memory address, stable while a strobe is high
data_in  in  8  memory data bus (write data or read data)
par_in  in  1  parity bit read back from the parity RAM
par_chk_dis  in  1  PB4: 1 disables checking and clears the latch; 0 enables checking
nmi_en  in  1  NMI mask register bit (port A0 bit 7)
io_chk_n  in  1  I/O channel check from the expansion bus, active low
par_out  out  1  parity bit to be written to the parity RAM
par_we  out  1  parity RAM write enable
par_err  out  1  sticky parity error (PC7)
io_err  out  1  sticky I/O channel check (PC6)
err_addr  out  AW  address of the first unacknowledged parity error
nmi  out  1  registered NMI request to the CPU

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, counter 0, par_err 0, io_err 0, err_addr 0, nmi 0.
- Parity instance: one ls280 with a..h = data_in[0..7] and i = par_in, producing odd and even.
- Write path (combinational): par_out = ~^data_in, so the stored 9-bit word always has odd parity. par_we = mem_wr & ~mem_rd.
- Read FSM states: IDLE, WAIT, CHECK, HOLD.
  - IDLE -> WAIT on a mem_rd rising edge (mem_rd = 1 and the previous-cycle mem_rd = 0); counter loads 1.
  - WAIT: counter increments each cycle. If mem_rd drops, go to IDLE with no check (aborted cycle). When counter = RD_WAIT, go to CHECK.
  - CHECK (one cycle): error = ls280 even output, meaning the 9-bit word has even ones.
    - If error = 1, par_chk_dis = 0 and par_err = 0: set par_err and capture err_addr <= addr.
    - Otherwise no update.
    - Go to HOLD if mem_rd = 1, else IDLE.
  - HOLD -> IDLE when mem_rd = 0.
- Sample timing: the sample is taken RD_WAIT+1 clocks after the first clk edge at which mem_rd is seen high.
- Sticky status:
  - par_err and err_addr hold until par_chk_dis = 1, which clears par_err the next cycle. err_addr is retained.
  - A second error while par_err = 1 does not overwrite err_addr.
  - If clear and a new error occur in the same cycle, clear wins.
- I/O check: io_chk_n is synchronised with a 2-flop synchroniser. io_err sets on a low synchronised value and clears only on reset.
- NMI: nmi <= nmi_en & (par_err | io_err), registered, so nmi follows par_err by 1 cycle.
- Simultaneous mem_rd and mem_wr: the read takes priority and par_we = 0.
- Reset asserted mid-cycle: everything returns to the reset values above. A read in flight is dropped and is not checked after reset release until a new mem_rd rising edge.

Decomposition:
- Shared package (ram_pkg): state encoding constants (IDLE = 0, WAIT = 1, CHECK = 2, HOLD = 3) and the default RD_WAIT.
- Sub-module: the existing ls280, instantiated once. No other sub-modules.

Test Plan:
1. Write data_in = 8'h03 with mem_wr = 1 -> par_out = 1, par_we = 1. Write data_in = 8'h07 -> par_out = 0.
2. Read addr = 20'h12345, data_in = 8'h03, par_in = 1, par_chk_dis = 0 -> par_err stays 0 across the whole cycle.
3. Read addr = 20'h0ABCD, data_in = 8'h03, par_in = 0, par_chk_dis = 0, nmi_en = 1 -> par_err = 1 at RD_WAIT+1 clocks after the strobe, err_addr = 20'h0ABCD, nmi = 1 one clock later.
   - A second bad read at 20'h00001 leaves err_addr = 20'h0ABCD.
4. Same bad read with par_chk_dis = 1 -> par_err = 0.
   - Set par_chk_dis = 1 after an error -> par_err = 0 the next clock.
   - With nmi_en = 0 on an error, nmi stays 0.
5. mem_rd pulsed for 1 cycle with RD_WAIT = 2 and bad parity -> no error (abort path). Assert reset_n = 0 while in WAIT -> all outputs 0 immediately.
6. io_chk_n driven low for 1 cycle with nmi_en = 1 -> io_err = 1 after 2 synchroniser clocks, nmi = 1 on the following clock.
